// File: rtl/status_flag_register_pkg.sv
// Purpose: shared constants, types and helpers for the status flag register block.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package status_flag_register_pkg;

    localparam int ADDR_W  = 11;
    localparam int DATA_W  = 8;
    localparam int CNT_W   = 8;
    localparam int NUM_SRC = 3;

    // Register map
    localparam logic [ADDR_W-1:0] STATUS_ADDR = 11'h008;
    localparam logic [ADDR_W-1:0] MASK_ADDR   = 11'h009;
    localparam logic [ADDR_W-1:0] CNT_BASE    = 11'h00A;
    localparam logic [ADDR_W-1:0] CNT1_ADDR   = 11'h00B;
    localparam logic [ADDR_W-1:0] CNT2_ADDR   = 11'h00C;

    // Status byte layout: each source owns an adjacent (flag, saturated) bit pair
    localparam int FLAG_POS_OVR  = 0;
    localparam int FLAG_POS_UND  = 2;
    localparam int FLAG_POS_FILT = 4;
    localparam int SAT_POS_OVR   = 1;
    localparam int SAT_POS_UND   = 3;
    localparam int SAT_POS_FILT  = 5;

    // Only the flag positions are meaningful in the mask register
    localparam logic [DATA_W-1:0] MASK_WR_BITS = 8'h15;

    // Source index order used for the event/clear/counter vectors
    typedef enum logic [1:0] {
        SRC_OVR  = 2'd0,
        SRC_UND  = 2'd1,
        SRC_FILT = 2'd2
    } src_e;

    // Per-source observable state
    typedef struct packed {
        logic             flag;
        logic             sat;
        logic [CNT_W-1:0] count;
    } src_stat_t;

    // Source i lands on status bit 2*i (flag) and 2*i+1 (saturated); bits 6,7 stay 0.
    function automatic logic [DATA_W-1:0] pack_status(input logic [NUM_SRC-1:0] flags,
                                                      input logic [NUM_SRC-1:0] sats);
        logic [DATA_W-1:0] s;
        s = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            s[2*i]   = flags[i];
            s[2*i+1] = sats[i];
        end
        return s;
    endfunction

endpackage

// File: rtl/status_flag_register_if.sv
// Purpose: register-bus bundle (address/write/read strobes and read data) for the status block.
// Latency: n/a (wires only).
// Backpressure: none; the bus has no stall, reads return one cycle after rd_en.
// Ports: address, wdata, xfc, rd_en driven by master; rdata driven by slave.
interface status_flag_register_if;
    import status_flag_register_pkg::*;

    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] wdata;
    logic              xfc;
    logic              rd_en;
    logic [DATA_W-1:0] rdata;

    modport master (
        output address,
        output wdata,
        output xfc,
        output rd_en,
        input  rdata
    );

    modport slave (
        input  address,
        input  wdata,
        input  xfc,
        input  rd_en,
        output rdata
    );

endinterface

// File: rtl/status_flag_register_sticky_flag_counter.sv
// Purpose: one error source - sticky flag plus saturating event counter with clear.
// Latency: event/clear visible on flag/count one clock after the pulse.
// Backpressure: none; every pulse is accepted, counter saturates instead of wrapping.
// Ports: clk, rst_n, evt (event pulse), clr (clear pulse) -> flag, count, sat (count at max).
module sticky_flag_counter
    import status_flag_register_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         evt,
    input  logic         clr,
    output logic         flag,
    output logic [W-1:0] count,
    output logic         sat
);

    localparam logic [W-1:0] CNT_MAX = '1;
    localparam logic [W-1:0] CNT_ONE = W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag  <= 1'b0;
            count <= '0;
        end else if (evt) begin
            // Event beats a simultaneous clear: the clear wipes history and
            // this cycle's event is counted as the first one.
            flag <= 1'b1;
            if (clr) begin
                count <= CNT_ONE;
            end else if (count != CNT_MAX) begin
                count <= count + CNT_ONE;
            end
        end else if (clr) begin
            flag  <= 1'b0;
            count <= '0;
        end
    end

    assign sat = (count == CNT_MAX);

endmodule

// File: rtl/status_flag_register.sv
// Purpose: captures audio datapath error events into sticky flags/counters, serves them on reads, drives masked irq.
// Latency: rdata one clock after rd_en (pre-update state); irq one clock after flag/mask change.
// Backpressure: none; events and bus accesses are accepted every cycle.
// Ports: clk, rst_n; bus (slave: address, wdata, xfc, rd_en -> rdata); three event pulses;
//        three clear triggers; irq (registered, active-high).
module status_flag_register
    import status_flag_register_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst_n,
    status_flag_register_if.slave        bus,
    input  logic                         i2si_fifo_overrun,
    input  logic                         i2so_fifo_underrun,
    input  logic                         filter_ovf,
    input  logic                         trig_i2si_fifo_overrun_clr,
    input  logic                         trig_i2so_fifo_underrun_clr,
    input  logic                         trig_filter_ovf_flag_clear,
    output logic                         irq
);

    logic [NUM_SRC-1:0] evt_vec;
    logic [NUM_SRC-1:0] clr_vec;
    src_stat_t          src_stat [NUM_SRC];
    logic [NUM_SRC-1:0] flags;
    logic [NUM_SRC-1:0] sats;
    logic [DATA_W-1:0]  status_byte;
    logic [DATA_W-1:0]  mask_reg;
    logic [DATA_W-1:0]  rd_mux;

    assign evt_vec[SRC_OVR]  = i2si_fifo_overrun;
    assign evt_vec[SRC_UND]  = i2so_fifo_underrun;
    assign evt_vec[SRC_FILT] = filter_ovf;

    assign clr_vec[SRC_OVR]  = trig_i2si_fifo_overrun_clr;
    assign clr_vec[SRC_UND]  = trig_i2so_fifo_underrun_clr;
    assign clr_vec[SRC_FILT] = trig_filter_ovf_flag_clear;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        sticky_flag_counter #(
            .W (CNT_W)
        ) u_sfc (
            .clk   (clk),
            .rst_n (rst_n),
            .evt   (evt_vec[g]),
            .clr   (clr_vec[g]),
            .flag  (src_stat[g].flag),
            .count (src_stat[g].count),
            .sat   (src_stat[g].sat)
        );
        assign flags[g] = src_stat[g].flag;
        assign sats[g]  = src_stat[g].sat;
    end

    assign status_byte = pack_status(flags, sats);

    // Mask: only flag-position bits are stored. Writes to status/counter
    // addresses are ignored here; clears come only from the trigger pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_reg <= '0;
        end else if (bus.xfc && (bus.address == MASK_ADDR)) begin
            mask_reg <= bus.wdata & MASK_WR_BITS;
        end
    end

    // Read mux uses current register outputs, so a read in the same cycle
    // as an event/clear returns the value before that update.
    always_comb begin
        rd_mux = '0;
        case (bus.address)
            STATUS_ADDR: rd_mux = status_byte;
            MASK_ADDR:   rd_mux = mask_reg;
            CNT_BASE:    rd_mux = src_stat[SRC_OVR].count;
            CNT1_ADDR:   rd_mux = src_stat[SRC_UND].count;
            CNT2_ADDR:   rd_mux = src_stat[SRC_FILT].count;
            default:     rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rdata <= '0;
        end else if (bus.rd_en) begin
            bus.rdata <= rd_mux;
        end
    end

    // Saturated bits never match because the mask cannot hold them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq <= 1'b0;
        end else begin
            irq <= |(status_byte & mask_reg & MASK_WR_BITS);
        end
    end

endmodule

// File: tb/tb_status_flag_register.sv
// Purpose: directed self-checking bench for status_flag_register with a read-data scoreboard.
// Latency: reads checked one clock after rd_en; irq checked at the cycles it must change.
// Backpressure: n/a.
module tb_status_flag_register;
    import status_flag_register_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic i2si_fifo_overrun = 1'b0;
    logic i2so_fifo_underrun = 1'b0;
    logic filter_ovf = 1'b0;
    logic trig_i2si_fifo_overrun_clr = 1'b0;
    logic trig_i2so_fifo_underrun_clr = 1'b0;
    logic trig_filter_ovf_flag_clear = 1'b0;
    logic irq;

    int tests = 0;
    int fails = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    status_flag_register_if bus ();

    status_flag_register dut (
        .clk                         (clk),
        .rst_n                       (rst_n),
        .bus                         (bus),
        .i2si_fifo_overrun           (i2si_fifo_overrun),
        .i2so_fifo_underrun          (i2so_fifo_underrun),
        .filter_ovf                  (filter_ovf),
        .trig_i2si_fifo_overrun_clr  (trig_i2si_fifo_overrun_clr),
        .trig_i2so_fifo_underrun_clr (trig_i2so_fifo_underrun_clr),
        .trig_filter_ovf_flag_clear  (trig_filter_ovf_flag_clear),
        .irq                         (irq)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Issue a one-cycle read; the expected value goes into the scoreboard
    // and is popped when rdata is due.
    task automatic rd(input string tag, input logic [10:0] a, input logic [7:0] e);
        bus.address = a;
        bus.rd_en   = 1'b1;
        exp_q.push_back(e);
        tick();
        bus.rd_en = 1'b0;
        check(tag, bus.rdata, exp_q.pop_front());
    endtask

    task automatic wr(input logic [10:0] a, input logic [7:0] d);
        bus.address = a;
        bus.wdata   = d;
        bus.xfc     = 1'b1;
        tick();
        bus.xfc = 1'b0;
    endtask

    task automatic set_evt(input int src, input logic v);
        case (src)
            0:       i2si_fifo_overrun  = v;
            1:       i2so_fifo_underrun = v;
            default: filter_ovf         = v;
        endcase
    endtask

    task automatic set_clr(input int src, input logic v);
        case (src)
            0:       trig_i2si_fifo_overrun_clr  = v;
            1:       trig_i2so_fifo_underrun_clr = v;
            default: trig_filter_ovf_flag_clear  = v;
        endcase
    endtask

    task automatic pulse(input int src, input int n);
        for (int i = 0; i < n; i++) begin
            set_evt(src, 1'b1);
            tick();
            set_evt(src, 1'b0);
        end
    endtask

    task automatic clear(input int src);
        set_clr(src, 1'b1);
        tick();
        set_clr(src, 1'b0);
    endtask

    initial begin
        bus.address = '0;
        bus.wdata   = '0;
        bus.xfc     = 1'b0;
        bus.rd_en   = 1'b0;

        // Reset state
        #12;
        check("rst_rdata", bus.rdata, 8'h00);
        check("rst_irq", {7'b0, irq}, 8'h00);
        tick();
        rst_n = 1'b1;
        tick();
        rd("rst_status", STATUS_ADDR, 8'h00);
        rd("rst_mask",   MASK_ADDR,   8'h00);
        rd("rst_cnt0",   CNT_BASE,    8'h00);
        rd("rst_cnt1",   CNT1_ADDR,   8'h00);
        rd("rst_cnt2",   CNT2_ADDR,   8'h00);
        rd("unmapped",   11'h00D,     8'h00);
        check("rst_irq_after", {7'b0, irq}, 8'h00);

        // Overrun: three pulses then clear
        pulse(0, 3);
        rd("ovr_status", STATUS_ADDR, 8'h01);
        rd("ovr_cnt",    CNT_BASE,    8'h03);
        clear(0);
        rd("ovr_status_clr", STATUS_ADDR, 8'h00);
        rd("ovr_cnt_clr",    CNT_BASE,    8'h00);

        // Underrun saturation
        pulse(1, 260);
        rd("und_cnt_sat",    CNT1_ADDR,   8'hFF);
        rd("und_status_sat", STATUS_ADDR, 8'h0C);
        clear(1);
        rd("und_cnt_clr",    CNT1_ADDR,   8'h00);
        rd("und_status_clr", STATUS_ADDR, 8'h00);

        // Filter event and clear in the same cycle: event wins
        filter_ovf = 1'b1;
        trig_filter_ovf_flag_clear = 1'b1;
        tick();
        filter_ovf = 1'b0;
        trig_filter_ovf_flag_clear = 1'b0;
        rd("filt_status_race", STATUS_ADDR, 8'h10);
        rd("filt_cnt_race",    CNT2_ADDR,   8'h01);
        clear(2);
        rd("filt_status_clr", STATUS_ADDR, 8'h00);

        // Mask write and irq timing
        wr(MASK_ADDR, 8'hFF);
        rd("mask_rd", MASK_ADDR, 8'h15);
        check("irq_idle", {7'b0, irq}, 8'h00);
        i2si_fifo_overrun = 1'b1;
        tick();
        i2si_fifo_overrun = 1'b0;
        check("irq_n1", {7'b0, irq}, 8'h00);
        tick();
        check("irq_n2", {7'b0, irq}, 8'h01);

        // Writes to status are ignored by storage
        wr(STATUS_ADDR, 8'hFF);
        rd("status_wr_ignored", STATUS_ADDR, 8'h01);

        // Read in the same cycle as an event returns the pre-update value
        bus.address = CNT_BASE;
        bus.rd_en = 1'b1;
        i2si_fifo_overrun = 1'b1;
        exp_q.push_back(8'h01);
        tick();
        bus.rd_en = 1'b0;
        i2si_fifo_overrun = 1'b0;
        check("read_pre_update", bus.rdata, exp_q.pop_front());
        rd("read_post_update", CNT_BASE, 8'h02);

        // rdata holds while rd_en is low
        bus.address = STATUS_ADDR;
        tick();
        tick();
        check("rdata_hold", bus.rdata, 8'h02);

        // Mask cleared: irq drops two cycles after the write cycle
        wr(MASK_ADDR, 8'h00);
        check("irq_mask_m1", {7'b0, irq}, 8'h01);
        tick();
        check("irq_mask_m2", {7'b0, irq}, 8'h00);

        // Asynchronous reset mid-burst
        wr(MASK_ADDR, 8'h15);
        tick();
        check("irq_pre_reset", {7'b0, irq}, 8'h01);
        pulse(1, 5);
        rd("und_cnt_burst", CNT1_ADDR, 8'h05);
        i2so_fifo_underrun = 1'b1;
        tick();
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_rdata", bus.rdata, 8'h00);
        check("arst_irq", {7'b0, irq}, 8'h00);
        i2so_fifo_underrun = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
        rd("post_rst_cnt0",   CNT_BASE,    8'h00);
        rd("post_rst_cnt1",   CNT1_ADDR,   8'h00);
        rd("post_rst_status", STATUS_ADDR, 8'h00);
        rd("post_rst_mask",   MASK_ADDR,   8'h00);
        check("post_rst_irq", {7'b0, irq}, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
